regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Tracks which architectural registers have a write still outstanding
//   (scoreboard "busy" bits). It stalls decode on RAW/WAW hazards and
//   arbitrates between two writeback sources (ALU and load unit) for the
//   single register-file write port. Arbitration is round-robin when both
//   sources compete. The chosen writeback is registered onto the port.
//
// Parameters:
//   INIT_PRIO      requester favoured first after reset (0 = ALU, 1 = load)
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   issue_valid    decode wants to reserve issue_rd
//   issue_rd       destination register of the issuing instruction
//   issue_ready    issue accepted this cycle
//   rs1_addr       first source register of the issuing instruction
//   rs2_addr       second source register of the issuing instruction
//   hazard         a source register still has a write pending
//   req0_*         ALU writeback request (valid/addr/data) and grant (ready)
//   req1_*         load-unit writeback request (valid/addr/data) and grant
//   write_ena      register-file write enable (registered)
//   write_reg_addr register-file write address (registered)
//   data_in        register-file write data (registered)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        write_ena,
    output logic [4:0]  write_reg_addr,
    output logic [31:0] data_in
);

    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        prio;
    logic        wb_grant;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_accept;

    // Hazard detection looks only at the registered busy vector, so a
    // writeback retiring this cycle still stalls a dependent issue for one
    // cycle. Everything is forced low while reset is held so that nothing
    // upstream sees a handshake during reset.
    always_comb begin
        hazard      = 1'b0;
        issue_ready = 1'b0;
        if (!rst) begin
            hazard      = busy[rs1_addr] | busy[rs2_addr];
            issue_ready = !busy[issue_rd] & !(busy[rs1_addr] | busy[rs2_addr]);
        end
    end

    // Writeback arbitration: a lone request always wins; when both are
    // valid the requester named by prio wins. req1 is granted exactly when
    // it is valid and req0 did not win, so at most one grant per cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            req0_ready = req0_valid & (!req1_valid | (prio == 1'b0));
            req1_ready = req1_valid & !(req0_valid & (!req1_valid | (prio == 1'b0)));
        end
    end

    // Mux the winning request onto a common writeback path.
    always_comb begin
        wb_grant     = req0_ready | req1_ready;
        wb_addr      = req1_ready ? req1_addr : req0_addr;
        wb_data      = req1_ready ? req1_data : req0_data;
        issue_accept = issue_valid & issue_ready & (issue_rd != 5'd0);
    end

    // Next busy vector: clear the retiring register first, then apply the
    // new reservation so that a same-register set overrides the clear.
    // Register 0 never holds a pending write.
    always_comb begin
        busy_next = busy;
        if (wb_grant) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Round-robin pointer only moves when there was real contention, so a
    // stream of single requests does not disturb fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= INIT_PRIO;
        end else if (req0_valid && req1_valid) begin
            prio <= ~prio;
        end
    end

    // Register-file write port. A grant to register 0 is consumed but does
    // not produce a write. Address and data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_ena      <= 1'b0;
            write_reg_addr <= 5'd0;
            data_in        <= 32'd0;
        end else begin
            write_ena <= wb_grant & (wb_addr != 5'd0);
            if (wb_grant) begin
                write_reg_addr <= wb_addr;
                data_in        <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. A behavioural model of the
// busy vector and round-robin pointer predicts the combinational outputs
// every cycle; each expected register-file write is pushed to a scoreboard
// queue at grant time and popped when the registered port is sampled.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam bit INIT_PRIO = 1'b0;

    typedef struct {
        logic        ena;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        write_ena;
    logic [4:0]  write_reg_addr;
    logic [31:0] data_in;

    int          assertions_evaluated = 0;
    int          failures = 0;

    logic [31:0] m_busy = '0;
    logic        m_prio = INIT_PRIO;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    wr_t         sb_q[$];

    regfile_wb_arbiter #(.INIT_PRIO(INIT_PRIO)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .hazard         (hazard),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .write_ena      (write_ena),
        .write_reg_addr (write_reg_addr),
        .data_in        (data_in)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions_evaluated++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs (called just after a falling edge), checks
    // the combinational outputs against the model, advances the model and
    // the scoreboard, then checks the registered outputs after the edge.
    task automatic applyStimulus(input logic r, input logic iv, input logic [4:0] rd,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        logic        e_hz;
        logic        e_ir;
        logic        e_g0;
        logic        e_g1;
        logic [31:0] nb;
        wr_t         e;

        rst = r; issue_valid = iv; issue_rd = rd; rs1_addr = s1; rs2_addr = s2;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;

        if (r) begin
            e_hz = 1'b0; e_ir = 1'b0; e_g0 = 1'b0; e_g1 = 1'b0;
        end else begin
            e_hz = m_busy[s1] | m_busy[s2];
            e_ir = !m_busy[rd] && !e_hz;
            if (v0 && v1) begin
                e_g0 = (m_prio == 1'b0);
                e_g1 = (m_prio == 1'b1);
            end else begin
                e_g0 = v0;
                e_g1 = v1;
            end
        end
        checkOutput("hazard", 32'(hazard), 32'(e_hz));
        checkOutput("issue_ready", 32'(issue_ready), 32'(e_ir));
        checkOutput("req0_ready", 32'(req0_ready), 32'(e_g0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(e_g1));

        if (r) begin
            m_busy = '0;
            m_prio = INIT_PRIO;
            sb_q.delete();
        end else begin
            nb = m_busy;
            if (e_g0) begin
                nb[a0] = 1'b0;
                sb_q.push_back('{ena: (a0 != 5'd0), addr: a0, data: d0});
            end
            if (e_g1) begin
                nb[a1] = 1'b0;
                sb_q.push_back('{ena: (a1 != 5'd0), addr: a1, data: d1});
            end
            if (iv && e_ir && rd != 5'd0) nb[rd] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            if (v0 && v1) m_prio = ~m_prio;
        end

        @(posedge clk);
        #1;
        if (r) begin
            e = '{ena: 1'b0, addr: 5'd0, data: 32'd0};
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e = '{ena: 1'b0, addr: m_waddr, data: m_wdata};
        end
        m_waddr = e.addr;
        m_wdata = e.data;
        checkOutput("write_ena", 32'(write_ena), 32'(e.ena));
        checkOutput("write_reg_addr", 32'(write_reg_addr), 32'(e.addr));
        checkOutput("data_in", data_in, e.data);
        checkOutput("busy", dut.busy, m_busy);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 5, 5, 5, 1, 5, 32'h1, 1, 6, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] RAW hazard and ALU writeback");
        applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 5, 0, 1, 5, 32'h0114beef, 0, 0, 0);
        applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd5_retired", dut.busy, 32'h0);

        $display("[TB] round-robin contention");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h0ff1ce11, 1, 2, 32'h01111111);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] writeback to register 0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h01111111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] same-register set and clear");
        applyStimulus(0, 1, 3, 0, 0, 1, 3, 32'h00000033, 0, 0, 0);
        checkOutput("busy3_set_wins", 32'(dut.busy[3]), 32'h1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 0, 3, 1, 3, 32'h00000333, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset after grant");
        applyStimulus(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 8, 0, 0, 1, 7, 32'h00000077, 0, 0, 0);
        applyStimulus(1, 0, 0, 7, 8, 1, 8, 32'h00000088, 0, 0, 0);
        checkOutput("busy7_after_reset", 32'(dut.busy[7]), 32'h0);
        applyStimulus(0, 0, 0, 7, 8, 0, 0, 0, 0, 0, 0);

        $display("[TB] WAW stall on repeated issue");
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 1, 4, 32'h00000044);
        applyStimulus(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'h00000444, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
